// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch M0, load/store M1) to single-slave bus arbiter, one access in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise M1 has strict priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                m0_req_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    output logic                m0_ack_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_be_o,
    input  logic                s_ack_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic [1:0]          gnt_o,
    output logic                busy_o
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_reg;
    logic       sel_m1;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when M1 won the most recent grant; a tie goes to the other port.
    logic last_m1_reg;

    always_comb begin
        sel_m1 = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            sel_m1 = !last_m1_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_m1_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && (m0_req_i || m1_req_i)) begin
            last_m1_reg <= sel_m1;
        end
    end
`else
    assign sel_m1 = m1_req_i;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg  <= ST_IDLE;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            s_be_o     <= '0;
            gnt_o      <= 2'b00;
            busy_o     <= 1'b0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state_reg <= ST_BUSY;
                        s_req_o   <= 1'b1;
                        busy_o    <= 1'b1;
                        if (sel_m1) begin
                            gnt_o     <= 2'b10;
                            s_we_o    <= m1_we_i;
                            s_addr_o  <= m1_addr_i;
                            s_wdata_o <= m1_wdata_i;
                            s_be_o    <= m1_be_i;
                        end else begin
                            gnt_o     <= 2'b01;
                            s_we_o    <= 1'b0;
                            s_addr_o  <= m0_addr_i;
                            s_wdata_o <= '0;
                            s_be_o    <= {BE_W{1'b1}};
                        end
                    end
                end
                ST_BUSY: begin
                    // s_we_o still reflects the access here, so it selects read-data capture.
                    if (s_ack_i) begin
                        state_reg <= ST_DONE;
                        s_req_o   <= 1'b0;
                        s_we_o    <= 1'b0;
                        if (gnt_o[1]) begin
                            m1_ack_o <= 1'b1;
                            if (!s_we_o) begin
                                m1_rdata_o <= s_rdata_i;
                            end
                        end else begin
                            m0_ack_o   <= 1'b1;
                            m0_rdata_o <= s_rdata_i;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    m0_ack_o  <= 1'b0;
                    m1_ack_o  <= 1'b0;
                    gnt_o     <= 2'b00;
                    busy_o    <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed literal checks, then random traffic against a
// transaction-level ownership model compared on every falling clock edge.
module tb_mem_bus_arbiter;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        m0_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0;
    logic        m0_ack_o;
    logic [31:0] m0_rdata_o;
    logic        m1_req_i = 1'b0;
    logic        m1_we_i = 1'b0;
    logic [31:0] m1_addr_i = '0;
    logic [31:0] m1_wdata_i = '0;
    logic [3:0]  m1_be_i = '0;
    logic        m1_ack_o;
    logic [31:0] m1_rdata_o;
    logic        s_req_o;
    logic        s_we_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_ack_i = 1'b0;
    logic [31:0] s_rdata_i = '0;
    logic [1:0]  gnt_o;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_be_i(m1_be_i), .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_ack_i(s_ack_i), .s_rdata_i(s_rdata_i),
        .gnt_o(gnt_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: who owns the bus (-1 none), whether the slave has answered yet,
    // the captured access, and each port's last returned read data.
    int          own = -1;
    bit          acked = 1'b0;
    bit          e_we = 1'b0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_be = '0;
    logic [31:0] e_rd0 = '0;
    logic [31:0] e_rd1 = '0;
    bit          last_m1 = 1'b0;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            own = -1; acked = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0;
            e_rd0 = '0; e_rd1 = '0; last_m1 = 0;
        end else if (own < 0) begin
            if (m0_req_i || m1_req_i) begin
                int w;
`ifdef ARB_ROUND_ROBIN_EN
                if (m0_req_i && m1_req_i) w = last_m1 ? 0 : 1;
                else w = m1_req_i ? 1 : 0;
`else
                w = m1_req_i ? 1 : 0;
`endif
                last_m1 = (w == 1);
                own = w;
                if (w == 1) begin
                    e_we = m1_we_i; e_addr = m1_addr_i; e_wdata = m1_wdata_i; e_be = m1_be_i;
                end else begin
                    e_we = 0; e_addr = m0_addr_i; e_wdata = '0; e_be = 4'hF;
                end
            end
        end else if (!acked) begin
            if (s_ack_i) begin
                acked = 1;
                if (own == 0) e_rd0 = s_rdata_i;
                else if (!e_we) e_rd1 = s_rdata_i;
                $display("txn t=%0t port=M%0d we=%0d addr=%h wdata=%h be=%h rdata=%h",
                         $time, own, e_we, e_addr, e_wdata, e_be, s_rdata_i);
            end
        end else begin
            own = -1;
            acked = 0;
        end
    end

    always @(negedge clk_i) begin
        logic [138:0] got;
        logic [138:0] exp;
        logic         live;
        logic [1:0]   e_gnt;
        live  = (own >= 0);
        e_gnt = (own == 1) ? 2'b10 : (own == 0) ? 2'b01 : 2'b00;
        got = {s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o, gnt_o, busy_o,
               m0_ack_o, m1_ack_o, m0_rdata_o, m1_rdata_o};
        exp = {live && !acked, e_we && live && !acked, e_addr, e_wdata, e_be, e_gnt, live,
               acked && own == 0, acked && own == 1, e_rd0, e_rd1};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t got %h expected %h", $time, got, exp);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] tie_gnt [4];
        tie_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};

        step(); step();
        chk("reset_outputs", {s_req_o, s_we_o, gnt_o, busy_o, m0_ack_o, m1_ack_o}, 0);
        chk("reset_rdata", {m0_rdata_o, m1_rdata_o}, 0);
        rstn_i = 1'b1;
        step();

        // M0 fetch, slave answers two cycles after s_req_o rises
        m0_req_i = 1; m0_addr_i = 32'h10;
        step();
        chk("t1_req", {s_req_o, s_we_o, gnt_o, busy_o}, 5'b10011);
        chk("t1_addr", s_addr_o, 32'h10);
        chk("t1_be", s_be_o, 4'hF);
        step();
        chk("t1_wait", {m0_ack_o, m1_ack_o, s_req_o}, 3'b001);
        step();
        s_ack_i = 1; s_rdata_i = 32'h13;
        step();
        chk("t1_ack", {m0_ack_o, m1_ack_o, s_req_o}, 3'b100);
        chk("t1_rdata", m0_rdata_o, 32'h13);
        s_ack_i = 0; m0_req_i = 0;
        step();
        chk("t1_done", {m0_ack_o, gnt_o, busy_o}, 0);

        // M1 store
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h100; m1_wdata_i = 32'hDEADBEEF; m1_be_i = 4'b0011;
        step();
        chk("t2_req", {s_req_o, s_we_o, gnt_o}, 4'b1110);
        chk("t2_fields", {s_addr_o, s_wdata_o}, {32'h100, 32'hDEADBEEF});
        chk("t2_be", s_be_o, 4'b0011);
        s_ack_i = 1; s_rdata_i = 32'hCAFE0000;
        step();
        chk("t2_ack", {m1_ack_o, m0_ack_o, s_we_o, s_req_o}, 4'b1000);
        chk("t2_rdata_kept", m1_rdata_o, 32'h0);
        s_ack_i = 0; m1_req_i = 0; m1_we_i = 0;
        step();
        chk("t2_single_pulse", m1_ack_o, 0);

        // Spurious slave ack while idle
        s_ack_i = 1;
        step();
        s_ack_i = 0;
        chk("t6_idle_ack", {m0_ack_o, m1_ack_o, busy_o, s_req_o, gnt_o}, 0);

        // Simultaneous requests; each winner sits out one IDLE before re-requesting
        m0_req_i = 1; m0_addr_i = 32'h20;
        m1_req_i = 1; m1_addr_i = 32'h200;
        step();
        for (int k = 0; k < 4; k++) begin
            logic w1;
            chk($sformatf("t3_gnt%0d", k), gnt_o, tie_gnt[k]);
            w1 = gnt_o[1];
            s_ack_i = 1; s_rdata_i = 32'h3000 + k;
            step();
            s_ack_i = 0;
            if (w1) m1_req_i = 0; else m0_req_i = 0;
            step(); step();
            if (w1) m1_req_i = 1; else m0_req_i = 1;
        end
        s_ack_i = 1;
        step();
        s_ack_i = 0; m0_req_i = 0; m1_req_i = 0;
        step(); step();

        // Back-to-back fetches with immediate slave acks: one grant every 3 cycles
        m0_req_i = 1; m0_addr_i = 32'h1000;
        for (int c = 0; c < 12; c++) begin
            step();
            if (c % 3 == 0) chk("t4_busy", {s_req_o, gnt_o, m0_ack_o}, 4'b1010);
            else if (c % 3 == 1) chk("t4_ack", {s_req_o, gnt_o, m0_ack_o}, 4'b0011);
            else chk("t4_idle", {s_req_o, gnt_o, busy_o, m0_ack_o}, 0);
            s_ack_i = s_req_o;
            s_rdata_i = 32'h4000 + c;
            if (m0_ack_o) m0_addr_i = m0_addr_i + 4;
            if (c == 11) m0_req_i = 0;
        end
        s_ack_i = 0;
        step();

        // Reset while waiting on the slave
        m1_req_i = 1; m1_we_i = 0; m1_addr_i = 32'h300;
        step(); step();
        #2 rstn_i = 0;
        #1 chk("t5_async_clear", {s_req_o, gnt_o, busy_o}, 0);
        m1_req_i = 0;
        step(); step();
        rstn_i = 1;
        step();
        chk("t5_no_ack", {m0_ack_o, m1_ack_o, busy_o}, 0);
        m1_req_i = 1; m1_addr_i = 32'h400;
        step();
        chk("t5_fresh_gnt", {s_req_o, gnt_o}, 3'b110);
        s_ack_i = 1; s_rdata_i = 32'h55AA;
        step();
        chk("t5_fresh_ack", {m1_ack_o, m1_rdata_o}, {1'b1, 32'h55AA});
        s_ack_i = 0; m1_req_i = 0;
        step(); step();

        // Random traffic, occasional resets, spurious slave acks
        for (int n = 0; n < 3000; n++) begin
            step();
            rstn_i = ($urandom_range(0, 299) != 0);
            s_rdata_i = $urandom;
            if (s_req_o) s_ack_i = ($urandom_range(0, 2) == 0);
            else s_ack_i = ($urandom_range(0, 9) == 0);
            if (m0_ack_o) m0_req_i = 0;
            if (!m0_req_i && $urandom_range(0, 2) == 0) begin
                m0_req_i = 1; m0_addr_i = $urandom;
            end
            if (m1_ack_o) m1_req_i = 0;
            if (!m1_req_i && $urandom_range(0, 2) == 0) begin
                m1_req_i = 1; m1_we_i = $urandom_range(0, 1); m1_addr_i = $urandom;
                m1_wdata_i = $urandom; m1_be_i = $urandom_range(0, 15);
            end
        end
        rstn_i = 1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
